// File: rtl/cskipa_seq_adder_if.sv
// Handshake/data bundle for cskipa_seq_adder.
// Producer side: i_valid, i_add_term1, i_add_term2, i_cin -> block; o_ready <- block.
// Consumer side: o_valid, o_sum, o_cout <- block; i_ready -> block.
// Signal names are written from the adder's point of view.
// Modports: slave (the adder), master (producer + consumer environment).
interface cskipa_seq_adder_if #(
    parameter int unsigned SLICE   = 41,
    parameter int unsigned NSLICES = 4
);
    localparam int unsigned Width = SLICE * NSLICES;

    logic             i_valid;
    logic             o_ready;
    logic [Width-1:0] i_add_term1;
    logic [Width-1:0] i_add_term2;
    logic             i_cin;
    logic             o_valid;
    logic             i_ready;
    logic [Width-1:0] o_sum;
    logic             o_cout;

    modport slave (
        input  i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
        output o_ready, o_valid, o_sum, o_cout
    );

    modport master (
        output i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
        input  o_ready, o_valid, o_sum, o_cout
    );
endinterface

// File: rtl/cskipa_seq_adder.sv
// Multi-cycle wide adder: a SLICE*NSLICES-bit addition performed one slice per cycle
// through a single shared combinational carry-skip slice adder, carry held in a register.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      cskipa_seq_adder_if.slave: operand valid/ready in, result valid/ready out
// Optional feature: define CSEQ_EARLY_DONE_EN to finish early once the carry is zero
// and every remaining operand slice is zero (result identical, only latency changes).
module cskipa_seq_adder #(
    parameter int unsigned SLICE   = 41,
    parameter int unsigned NSLICES = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    cskipa_seq_adder_if.slave    bus
);
    localparam int unsigned Width   = SLICE * NSLICES;
    localparam int unsigned IdxW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int          SkipBlk = 4;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [IdxW-1:0]  idx_q, idx_d;

    logic [SLICE-1:0] a_sl, b_sl, s_sl;
    logic             c_sl;
    logic             last_slice;

    assign a_sl       = a_q[32'(idx_q) * SLICE +: SLICE];
    assign b_sl       = b_q[32'(idx_q) * SLICE +: SLICE];
    assign last_slice = (idx_q == IdxW'(NSLICES - 1));

    // Carry-skip slice adder: ripple inside SkipBlk-bit groups; a group whose bits all
    // propagate passes its incoming carry straight through.
    always_comb begin
        logic c, c_grp, p_grp, p, g;
        s_sl  = '0;
        c     = carry_q;
        c_grp = carry_q;
        p_grp = 1'b1;
        p     = 1'b0;
        g     = 1'b0;
        for (int i = 0; i < int'(SLICE); i++) begin
            p       = a_sl[i] ^ b_sl[i];
            g       = a_sl[i] & b_sl[i];
            s_sl[i] = p ^ c;
            c       = g | (p & c);
            p_grp   = p_grp & p;
            if (((i % SkipBlk) == SkipBlk - 1) || (i == int'(SLICE) - 1)) begin
                if (p_grp) begin
                    c = c_grp;
                end
                c_grp = c;
                p_grp = 1'b1;
            end
        end
        c_sl = c;
    end

`ifdef CSEQ_EARLY_DONE_EN
    // Any operand bit set in a slice above the current one.
    logic upper_nz;
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < int'(NSLICES); j++) begin
            if (j > int'(idx_q)) begin
                if ((|a_q[j * SLICE +: SLICE]) || (|b_q[j * SLICE +: SLICE])) begin
                    upper_nz = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_add_term1;
                    b_d     = bus.i_add_term2;
                    carry_d = bus.i_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[32'(idx_q) * SLICE +: SLICE] = s_sl;
                carry_d = c_sl;
                if (last_slice) begin
                    cout_d  = c_sl;
                    state_d = StDone;
`ifdef CSEQ_EARLY_DONE_EN
                end else if (!c_sl && !upper_nz) begin
                    // Upper result slices are already zero from the accept.
                    cout_d  = 1'b0;
                    state_d = StDone;
`endif
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (bus.i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.o_ready = (state_q == StIdle);
    assign bus.o_valid = (state_q == StDone);
    assign bus.o_sum   = sum_q;
    assign bus.o_cout  = cout_q;
endmodule
